// File: rtl/adc_pkg.sv
// Shared types and constants for the serial ADC frame reader.
// Build option LEADING_ZERO_CHECK_EN is consumed by the channel and top modules.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_QUIET   = 2'd2
    } state_t;

    localparam int DEF_FRAME_BITS   = 16;
    localparam int DEF_DATA_BITS    = 12;
    localparam int DEF_NUM_CH       = 2;
    localparam int DEF_QUIET_CYCLES = 1;

    // Counter width for a count of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_shift_channel.sv
// One serial data lane: MSB-first shift register and sample slice.
// With LEADING_ZERO_CHECK_EN defined, also flags any 1 in the leading frame bits.
module adc_shift_channel
    import adc_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 shift_en,
    input  logic                 sdata,
`ifdef LEADING_ZERO_CHECK_EN
    output logic                 lead_err,
`endif
    output logic [DATA_BITS-1:0] sample
);

    logic [FRAME_BITS-1:0] shift_r;
    logic [FRAME_BITS-1:0] next_s;
    logic                  unused_msb_s;

    // The sample view includes the bit arriving on this edge, so the final bit
    // of a frame lands in the output register on the same edge it is shifted.
    assign next_s       = {shift_r[FRAME_BITS-2:0], sdata};
    assign sample       = next_s[DATA_BITS-1:0];
    assign unused_msb_s = shift_r[FRAME_BITS-1];

    // Shift register: one new bit per edge while the frame is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= '0;
        end else if (shift_en) begin
            shift_r <= next_s;
        end else begin
            shift_r <= shift_r;
        end
    end

`ifdef LEADING_ZERO_CHECK_EN
    generate
        if (FRAME_BITS > DATA_BITS) begin : g_lead
            assign lead_err = |next_s[FRAME_BITS-1:DATA_BITS];
        end else begin : g_no_lead
            assign lead_err = 1'b0;
        end
    endgenerate
`endif

endmodule

// File: rtl/adc_serial_frame_reader.sv
// CS framing, bit counting and parallel sample capture for AD7476-class ADCs.
// Define LEADING_ZERO_CHECK_EN to add the ERR output (non-zero leading bits).
module adc_serial_frame_reader
    import adc_pkg::*;
#(
    parameter int FRAME_BITS   = DEF_FRAME_BITS,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
) (
    input  logic                        SCLK,
    input  logic                        RST_N,
    input  logic                        START,
    input  logic                        CONTINUOUS,
    input  logic [NUM_CH-1:0]           SDATA,
    output logic                        CS,
`ifdef LEADING_ZERO_CHECK_EN
    output logic [NUM_CH-1:0]           ERR,
`endif
    output logic [NUM_CH*DATA_BITS-1:0] DATA,
    output logic                        VALID,
    output logic                        BUSY
);

    localparam int CW = cnt_width(FRAME_BITS);
    localparam int QW = cnt_width(QUIET_CYCLES);
    localparam logic [CW-1:0] LAST_BIT   = CW'(FRAME_BITS - 1);
    localparam logic [QW-1:0] LAST_QUIET = QW'(QUIET_CYCLES - 1);

    state_t                        state_r;
    logic [CW-1:0]                 bit_cnt_r;
    logic [QW-1:0]                 quiet_cnt_r;
    logic                          cs_r;
    logic                          valid_r;
    logic                          busy_r;
    logic [NUM_CH*DATA_BITS-1:0]   data_r;
    logic [NUM_CH*DATA_BITS-1:0]   sample_s;
    logic                          shift_en_s;
    logic                          go_s;

    assign shift_en_s = (state_r == ST_CONVERT);
    assign go_s       = START | CONTINUOUS;

`ifdef LEADING_ZERO_CHECK_EN
    logic [NUM_CH-1:0] lead_s;
    logic [NUM_CH-1:0] err_r;
    assign ERR = err_r;
`endif

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            adc_shift_channel #(
                .FRAME_BITS (FRAME_BITS),
                .DATA_BITS  (DATA_BITS)
            ) u_ch (
                .clk      (SCLK),
                .rst_n    (RST_N),
                .shift_en (shift_en_s),
                .sdata    (SDATA[k]),
`ifdef LEADING_ZERO_CHECK_EN
                .lead_err (lead_s[k]),
`endif
                .sample   (sample_s[k*DATA_BITS +: DATA_BITS])
            );
        end
    endgenerate

    // Frame FSM with registered CS/BUSY/VALID and the captured sample bank.
    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= '0;
            quiet_cnt_r <= '0;
            cs_r        <= 1'b1;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            data_r      <= '0;
`ifdef LEADING_ZERO_CHECK_EN
            err_r       <= '0;
`endif
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        state_r   <= ST_CONVERT;
                        cs_r      <= 1'b0;
                        busy_r    <= 1'b1;
                        bit_cnt_r <= '0;
                    end else begin
                        cs_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                ST_CONVERT: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        state_r     <= ST_QUIET;
                        bit_cnt_r   <= '0;
                        quiet_cnt_r <= '0;
                        cs_r        <= 1'b1;
                        data_r      <= sample_s;
                        valid_r     <= 1'b1;
`ifdef LEADING_ZERO_CHECK_EN
                        err_r       <= lead_s;
`endif
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                    end
                end
                ST_QUIET: begin
                    // START/CONTINUOUS only matter on the last quiet cycle.
                    if (quiet_cnt_r == LAST_QUIET) begin
                        if (go_s) begin
                            state_r <= ST_CONVERT;
                            cs_r    <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        quiet_cnt_r <= quiet_cnt_r + QW'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= '0;
                    cs_r      <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign CS    = cs_r;
    assign DATA  = data_r;
    assign VALID = valid_r;
    assign BUSY  = busy_r;

endmodule
